mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Resolves branches and jumps, and runs each load/store as a req/ack transaction with a variable-latency data memory.
- Stalls the front of the pipeline while an access is pending.
- Contains the MEM/WB pipeline register that feeds writeback.

Parameters:
AWIDTH, 32, address width
DWIDTH, 32, data width
TOUT, 255, max cycles waiting for dm_ack before bus error (1..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
memwr, memrd  in  1 each  store/load request from EX/MEM
bbne, bbeq, bblez, bbgtz, jump  in  1 each  branch/jump flags from EX/MEM
memtoreg  in  2  writeback source select from EX/MEM
regwr, fin  in  1 each  register write enable, program-finished flag
zero, negative  in  1 each  ALU flags
aluout  in  DWIDTH  ALU result; also the memory address
regdata2  in  DWIDTH  store data
regdstmux  in  5  destination register
branaddr, jmpaddr, pcnext  in  AWIDTH each  branch target, jump target, PC+4
dm_req  out  1  memory request
dm_we  out  1  1=write, 0=read
dm_addr  out  AWIDTH  memory address
dm_wdata  out  DWIDTH  memory write data
dm_rdata  in  DWIDTH  memory read data
dm_ack  in  1  memory completion, single-cycle pulse
stall  out  1  freeze PC/IF/ID/EX and EX/MEM
pcsrc  out  1  redirect PC
pctarget  out  AWIDTH  redirect address
flush  out  1  squash IF/ID and ID/EX
wb_memtoreg  out  2  MEM/WB copy of memtoreg
wb_regwr, wb_fin  out  1 each  MEM/WB copies of regwr, fin
wb_rdata, wb_aluout  out  DWIDTH each  loaded data, ALU result
wb_regdst  out  5  MEM/WB copy of regdstmux
wb_pcnext  out  AWIDTH  MEM/WB copy of pcnext
buserr  out  1  sticky timeout flag

Behaviour:
- Branch logic is combinational.
  - taken = (bbeq&zero) | (bbne&~zero) | (bblez&(zero|negative)) | (bbgtz&~zero&~negative) | jump.
  - pcsrc = flush = taken & ~stall.
  - pctarget = jump ? jmpaddr : branaddr.
- Branch flags together with memrd/memwr are illegal; behaviour is don't-care.
- access = memrd | memwr.
- FSM states: IDLE, BUSY, DONE.
  - IDLE & access -> BUSY. On that edge, register dm_req=1, dm_we=memwr, dm_addr=aluout[AWIDTH-1:0], dm_wdata=regdata2, and clear the timeout counter.
  - BUSY & dm_ack -> DONE. On that edge, capture rdbuf=dm_rdata for a read (0 for a write) and drop dm_req.
  - BUSY & ~dm_ack: counter increments. When counter==TOUT-1, go to DONE, set buserr=1, rdbuf=0, drop dm_req.
  - DONE -> IDLE unconditionally.
- dm_we, dm_addr and dm_wdata are held stable throughout BUSY. dm_ack is ignored outside BUSY.
- If dm_ack and the timeout coincide, ack wins and buserr is not set.
- stall = (IDLE & access) | BUSY. stall is 0 in DONE.
- Minimum memory-op occupancy is 3 cycles (IDLE, BUSY with immediate ack, DONE). A non-memory instruction takes 1 cycle.
- MEM/WB register updates on the rising edge:
  - stall=0: load all wb_* from the current inputs; wb_rdata=rdbuf.
  - stall=1: insert a bubble. wb_regwr=0 and wb_fin=0; all other wb_* hold.
- Reset (synchronous, overrides everything):
  - state=IDLE, counter=0.
  - dm_req=dm_we=0, dm_addr=dm_wdata=0, rdbuf=0, buserr=0.
  - All wb_* = 0.
  - stall, pcsrc and flush then follow their equations from the current inputs.
- Reset mid-BUSY abandons the transaction: dm_req=0 the next cycle, and a later dm_ack is ignored.
- buserr stays set until reset.

Test Plan:
- ALU op: regwr=1, regdstmux=5, aluout=0x1234, no access -> stall=0, dm_req never asserted; next edge wb_regwr=1, wb_regdst=5, wb_aluout=0x1234.
- Load: memrd=1, aluout=0x40, dm_ack 2 cycles after dm_req rises with dm_rdata=0xDEADBEEF -> dm_addr=0x40, dm_we=0, stall high for 4 cycles, wb_regwr=0 during the stall; edge after DONE gives wb_rdata=0xDEADBEEF.
- Store: memwr=1, aluout=0x80, regdata2=0xCAFE, immediate ack -> dm_we=1, dm_wdata=0xCAFE, stall exactly 2 cycles, wb_rdata=0.
- Branches:
  - bbeq=1, zero=1, branaddr=0x100 -> pcsrc=flush=1, pctarget=0x100.
  - bbgtz=1, negative=1 -> pcsrc=0.
  - jump=1, jmpaddr=0x200 -> pctarget=0x200.
- Timeout: TOUT=4, memrd=1, dm_ack held 0 -> dm_req drops after 4 BUSY cycles, buserr=1, wb_rdata=0; buserr persists until rst.
- Reset during BUSY: rst=1 for one cycle, then a dm_ack pulse -> dm_req=0, state IDLE, wb_* all 0, buserr=0, ack has no effect.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_ctrl
// Description : MEM-stage control. Resolves branches, runs loads/stores as
//               req/ack memory transactions, and holds the MEM/WB register.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int TOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    // EX/MEM pipeline register outputs
    input  logic              memwr,
    input  logic              memrd,
    input  logic              bbne,
    input  logic              bbeq,
    input  logic              bblez,
    input  logic              bbgtz,
    input  logic              jump,
    input  logic [1:0]        memtoreg,
    input  logic              regwr,
    input  logic              fin,
    input  logic              zero,
    input  logic              negative,
    input  logic [DWIDTH-1:0] aluout,
    input  logic [DWIDTH-1:0] regdata2,
    input  logic [4:0]        regdstmux,
    input  logic [AWIDTH-1:0] branaddr,
    input  logic [AWIDTH-1:0] jmpaddr,
    input  logic [AWIDTH-1:0] pcnext,
    // data memory
    output logic              dm_req,
    output logic              dm_we,
    output logic [AWIDTH-1:0] dm_addr,
    output logic [DWIDTH-1:0] dm_wdata,
    input  logic [DWIDTH-1:0] dm_rdata,
    input  logic              dm_ack,
    // pipeline control
    output logic              stall,
    output logic              pcsrc,
    output logic [AWIDTH-1:0] pctarget,
    output logic              flush,
    // MEM/WB pipeline register
    output logic [1:0]        wb_memtoreg,
    output logic              wb_regwr,
    output logic              wb_fin,
    output logic [DWIDTH-1:0] wb_rdata,
    output logic [DWIDTH-1:0] wb_aluout,
    output logic [4:0]        wb_regdst,
    output logic [AWIDTH-1:0] wb_pcnext,
    output logic              buserr
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [7:0] c_TOUT_LAST = 8'(TOUT - 1);

    logic [1:0]        r_state;
    logic [7:0]        r_cnt;
    logic [DWIDTH-1:0] r_rdbuf;

    logic              w_access;
    logic              w_taken;
    logic              w_stall;
    logic [AWIDTH-1:0] w_addr;

    // The memory address is the low AWIDTH bits of the ALU result.
    generate
        if (AWIDTH <= DWIDTH) begin : g_addr_trunc
            assign w_addr = aluout[AWIDTH-1:0];
        end else begin : g_addr_zext
            assign w_addr = {{(AWIDTH-DWIDTH){1'b0}}, aluout};
        end
    endgenerate

    assign w_access = memrd | memwr;

    assign w_taken = (bbeq  & zero)
                   | (bbne  & ~zero)
                   | (bblez & (zero | negative))
                   | (bbgtz & ~zero & ~negative)
                   | jump;

    assign w_stall  = ((r_state == c_IDLE) & w_access) | (r_state == c_BUSY);
    assign stall    = w_stall;
    assign pcsrc    = w_taken & ~w_stall;
    assign flush    = w_taken & ~w_stall;
    assign pctarget = jump ? jmpaddr : branaddr;

    // Memory transaction sequencer; dm_* stay stable for the whole BUSY phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_rdbuf  <= '0;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
            buserr   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_access) begin
                        r_state  <= c_BUSY;
                        r_cnt    <= '0;
                        dm_req   <= 1'b1;
                        dm_we    <= memwr;
                        dm_addr  <= w_addr;
                        dm_wdata <= regdata2;
                    end
                end
                c_BUSY: begin
                    if (dm_ack) begin
                        // An ack on the final allowed cycle still completes normally.
                        r_state <= c_DONE;
                        dm_req  <= 1'b0;
                        r_rdbuf <= dm_we ? '0 : dm_rdata;
                    end else if (r_cnt == c_TOUT_LAST) begin
                        r_state <= c_DONE;
                        dm_req  <= 1'b0;
                        r_rdbuf <= '0;
                        buserr  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // MEM/WB register: a stalled cycle becomes a bubble with no side effects.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_memtoreg <= '0;
            wb_regwr    <= 1'b0;
            wb_fin      <= 1'b0;
            wb_rdata    <= '0;
            wb_aluout   <= '0;
            wb_regdst   <= '0;
            wb_pcnext   <= '0;
        end else if (w_stall) begin
            wb_regwr <= 1'b0;
            wb_fin   <= 1'b0;
        end else begin
            wb_memtoreg <= memtoreg;
            wb_regwr    <= regwr;
            wb_fin      <= fin;
            wb_rdata    <= r_rdbuf;
            wb_aluout   <= aluout;
            wb_regdst   <= regdstmux;
            wb_pcnext   <= pcnext;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_ctrl
// Description : Directed bench for mem_stage_ctrl with a cycle-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          memwr, memrd, bbne, bbeq, bblez, bbgtz, jump;
    logic [1:0]    memtoreg;
    logic          regwr, fin, zero, negative;
    logic [DW-1:0] aluout, regdata2;
    logic [4:0]    regdstmux;
    logic [AW-1:0] branaddr, jmpaddr, pcnext;
    logic          dm_req, dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;
    logic          dm_ack;
    logic          stall, pcsrc, flush;
    logic [AW-1:0] pctarget;
    logic [1:0]    wb_memtoreg;
    logic          wb_regwr, wb_fin;
    logic [DW-1:0] wb_rdata, wb_aluout;
    logic [4:0]    wb_regdst;
    logic [AW-1:0] wb_pcnext;
    logic          buserr;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    mem_stage_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .TOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .memwr(memwr), .memrd(memrd), .bbne(bbne), .bbeq(bbeq), .bblez(bblez),
        .bbgtz(bbgtz), .jump(jump), .memtoreg(memtoreg), .regwr(regwr), .fin(fin),
        .zero(zero), .negative(negative), .aluout(aluout), .regdata2(regdata2),
        .regdstmux(regdstmux), .branaddr(branaddr), .jmpaddr(jmpaddr), .pcnext(pcnext),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .stall(stall), .pcsrc(pcsrc), .pctarget(pctarget), .flush(flush),
        .wb_memtoreg(wb_memtoreg), .wb_regwr(wb_regwr), .wb_fin(wb_fin),
        .wb_rdata(wb_rdata), .wb_aluout(wb_aluout), .wb_regdst(wb_regdst),
        .wb_pcnext(wb_pcnext), .buserr(buserr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: a memory op is tracked by how long it has waited for the bus.
    // wait_age = 0 means no request outstanding, k>0 means the k-th cycle
    // with the request up; last_cycle marks the single wrap-up cycle.
    // ------------------------------------------------------------------
    int            wait_age   = 0;
    bit            last_cycle = 1'b0;
    logic          m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_rdbuf = '0;
    logic          m_buserr = 1'b0;
    logic [1:0]    m_wb_memtoreg = '0;
    logic          m_wb_regwr = 1'b0, m_wb_fin = 1'b0;
    logic [DW-1:0] m_wb_rdata = '0, m_wb_aluout = '0;
    logic [4:0]    m_wb_regdst = '0;
    logic [AW-1:0] m_wb_pcnext = '0;

    always @(negedge clk) begin
        bit want_mem, e_stall, e_taken;
        want_mem = memrd | memwr;
        e_stall  = (wait_age > 0) || (wait_age == 0 && !last_cycle && want_mem);
        e_taken  = jump
                || (bbeq && zero) || (bbne && !zero)
                || (bblez && (zero || negative))
                || (bbgtz && !zero && !negative);
        if (chk_en) begin
            check("stall",       stall,       e_stall);
            check("pcsrc",       pcsrc,       e_taken && !e_stall);
            check("flush",       flush,       e_taken && !e_stall);
            check("pctarget",    pctarget,    jump ? jmpaddr : branaddr);
            check("dm_req",      dm_req,      wait_age > 0);
            check("dm_we",       dm_we,       m_we);
            check("dm_addr",     dm_addr,     m_addr);
            check("dm_wdata",    dm_wdata,    m_wdata);
            check("buserr",      buserr,      m_buserr);
            check("wb_memtoreg", wb_memtoreg, m_wb_memtoreg);
            check("wb_regwr",    wb_regwr,    m_wb_regwr);
            check("wb_fin",      wb_fin,      m_wb_fin);
            check("wb_rdata",    wb_rdata,    m_wb_rdata);
            check("wb_aluout",   wb_aluout,   m_wb_aluout);
            check("wb_regdst",   wb_regdst,   m_wb_regdst);
            check("wb_pcnext",   wb_pcnext,   m_wb_pcnext);
        end
        // Advance to the values the coming rising edge must produce.
        if (rst) begin
            wait_age = 0; last_cycle = 1'b0;
            m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rdbuf = '0; m_buserr = 1'b0;
            m_wb_memtoreg = '0; m_wb_regwr = 1'b0; m_wb_fin = 1'b0; m_wb_rdata = '0;
            m_wb_aluout = '0; m_wb_regdst = '0; m_wb_pcnext = '0;
        end else begin
            if (e_stall) begin
                m_wb_regwr = 1'b0;
                m_wb_fin   = 1'b0;
            end else begin
                m_wb_memtoreg = memtoreg; m_wb_regwr = regwr; m_wb_fin = fin;
                m_wb_rdata = m_rdbuf; m_wb_aluout = aluout;
                m_wb_regdst = regdstmux; m_wb_pcnext = pcnext;
            end
            if (last_cycle) begin
                last_cycle = 1'b0;
            end else if (wait_age > 0) begin
                if (dm_ack) begin
                    m_rdbuf = m_we ? '0 : dm_rdata;
                    wait_age = 0; last_cycle = 1'b1;
                end else if (wait_age == TO) begin
                    m_rdbuf = '0; m_buserr = 1'b1;
                    wait_age = 0; last_cycle = 1'b1;
                end else begin
                    wait_age = wait_age + 1;
                end
            end else if (want_mem) begin
                wait_age = 1;
                m_we = memwr; m_addr = aluout; m_wdata = regdata2;
            end
        end
    end

    task automatic clear_inputs();
        memwr = 0; memrd = 0; bbne = 0; bbeq = 0; bblez = 0; bbgtz = 0; jump = 0;
        memtoreg = '0; regwr = 0; fin = 0; zero = 0; negative = 0;
        aluout = '0; regdata2 = '0; regdstmux = '0;
        branaddr = '0; jmpaddr = '0; pcnext = '0;
        dm_rdata = '0; dm_ack = 0;
    endtask

    // Runs one load/store for ncyc cycles with dm_ack high during cycle ack_cyc.
    task automatic mem_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int ack_cyc, input logic [31:0] rdata, input int ncyc,
                          output int st_cnt, output int rq_cnt);
        st_cnt = 0; rq_cnt = 0;
        memwr = we; memrd = ~we; aluout = addr; regdata2 = wdata;
        regwr = ~we; memtoreg = we ? 2'd0 : 2'd1; regdstmux = 5'd9;
        pcnext = addr + 32'd4; dm_rdata = rdata;
        for (int i = 0; i < ncyc; i++) begin
            dm_ack = (i == ack_cyc);
            @(negedge clk);
            if (stall)  st_cnt++;
            if (dm_req) rq_cnt++;
            if (i == 1) check("bubble_regwr", wb_regwr, 1'b0);
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    initial begin
        int st, rq;
        clear_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_stall",  stall,    1'b0);
        check("rst_dm_req", dm_req,   1'b0);
        check("rst_buserr", buserr,   1'b0);
        check("rst_wb",     wb_regwr, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ALU op
        regwr = 1; regdstmux = 5'd5; aluout = 32'h1234; pcnext = 32'h8;
        @(negedge clk);
        check("alu_stall",  stall,  1'b0);
        check("alu_dm_req", dm_req, 1'b0);
        @(posedge clk); #1;
        check("alu_wb_regwr",  wb_regwr,  1'b1);
        check("alu_wb_regdst", wb_regdst, 5'd5);
        check("alu_wb_aluout", wb_aluout, 32'h1234);
        clear_inputs();

        // Load, ack two cycles after the request rises
        mem_op(1'b0, 32'h40, 32'h0, 3, 32'hDEADBEEF, 5, st, rq);
        check("ld_stall_cycles", st, 4);
        check("ld_req_cycles",   rq, 3);
        check("ld_wb_rdata",     wb_rdata, 32'hDEADBEEF);
        check("ld_dm_addr",      dm_addr,  32'h40);
        check("ld_dm_we",        dm_we,    1'b0);
        check("ld_wb_regwr",     wb_regwr, 1'b1);

        // Store, immediate ack; read data on the bus must be ignored
        mem_op(1'b1, 32'h80, 32'hCAFE, 1, 32'h12345678, 3, st, rq);
        check("st_stall_cycles", st, 2);
        check("st_req_cycles",   rq, 1);
        check("st_dm_we",        dm_we,    1'b1);
        check("st_dm_wdata",     dm_wdata, 32'hCAFE);
        check("st_wb_rdata",     wb_rdata, 32'h0);

        // Branches
        bbeq = 1; zero = 1; branaddr = 32'h100; jmpaddr = 32'h200; #1;
        check("beq_pcsrc", pcsrc, 1'b1);
        check("beq_flush", flush, 1'b1);
        check("beq_tgt",   pctarget, 32'h100);
        @(posedge clk); #1; clear_inputs();
        bbgtz = 1; negative = 1; branaddr = 32'h300; #1;
        check("bgtz_neg_pcsrc", pcsrc, 1'b0);
        @(posedge clk); #1; clear_inputs();
        jump = 1; jmpaddr = 32'h200; branaddr = 32'h100; #1;
        check("jmp_tgt",   pctarget, 32'h200);
        check("jmp_pcsrc", pcsrc, 1'b1);
        @(posedge clk); #1; clear_inputs();
        bblez = 1; negative = 1; #1;
        check("blez_neg_pcsrc", pcsrc, 1'b1);
        @(posedge clk); #1; clear_inputs();
        bbne = 1; zero = 1; #1;
        check("bne_zero_pcsrc", pcsrc, 1'b0);
        @(posedge clk); #1; clear_inputs();

        // Ack on the last allowed cycle beats the timeout
        mem_op(1'b0, 32'h44, 32'h0, 4, 32'hA5A5A5A5, 6, st, rq);
        check("edge_stall_cycles", st, 5);
        check("edge_req_cycles",   rq, 4);
        check("edge_buserr",       buserr,   1'b0);
        check("edge_wb_rdata",     wb_rdata, 32'hA5A5A5A5);

        // Timeout
        mem_op(1'b0, 32'h48, 32'h0, -1, 32'h0BADF00D, 6, st, rq);
        check("to_stall_cycles", st, 5);
        check("to_req_cycles",   rq, 4);
        check("to_buserr",       buserr,   1'b1);
        check("to_wb_rdata",     wb_rdata, 32'h0);
        regwr = 1; regdstmux = 5'd3; aluout = 32'h77;
        repeat (3) @(posedge clk);
        #1;
        check("to_buserr_sticky", buserr, 1'b1);
        clear_inputs();

        // Reset while BUSY, then a stray ack
        memrd = 1; aluout = 32'h50; regwr = 1; pcnext = 32'h60; regdstmux = 5'd4;
        @(posedge clk); #1;
        check("rb_dm_req_busy", dm_req, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_inputs();
        dm_ack = 1; dm_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        check("rb_dm_req",    dm_req,    1'b0);
        check("rb_stall",     stall,     1'b0);
        check("rb_buserr",    buserr,    1'b0);
        check("rb_wb_aluout", wb_aluout, 32'h0);
        check("rb_wb_pcnext", wb_pcnext, 32'h0);
        @(posedge clk); #1;
        dm_ack = 0;
        @(negedge clk);
        check("rb_ack_ignored", dm_req,   1'b0);
        check("rb_wb_rdata",    wb_rdata, 32'h0);
        check("rb_wb_regwr",    wb_regwr, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
